exposure_sequencer: RTL and testbench

//  Frame-level controller for the pixel Mealy FSM (Run/Reset inputs). One accepted start

---
 rtl/exposure_if.sv | 28 ++
 rtl/exposure_sequencer.sv | 153 +++++++++++++++
 tb/tb_exposure_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exposure_if.sv
// Frame-control bundle between the exposure sequencer and its host/ADC side.
// The master drives requests and handshakes; the slave (sequencer) drives the pixel-FSM controls and status.
interface exposure_if #(
    parameter int EXP_W = 8,
    parameter int ROW_W = 2
);
    logic             StartIN;
    logic             AbortIN;
    logic [EXP_W-1:0] ExpTimeIN;
    logic             ConvDoneIN;
    logic             FsmRunOUT;
    logic             FsmResetOUT;
    logic [ROW_W-1:0] RowAddrOUT;
    logic             ConvOUT;
    logic             BusyOUT;
    logic             DoneOUT;
    logic             ErrOUT;

    modport master (
        output StartIN, AbortIN, ExpTimeIN, ConvDoneIN,
        input  FsmRunOUT, FsmResetOUT, RowAddrOUT, ConvOUT, BusyOUT, DoneOUT, ErrOUT
    );

    modport slave (
        input  StartIN, AbortIN, ExpTimeIN, ConvDoneIN,
        output FsmRunOUT, FsmResetOUT, RowAddrOUT, ConvOUT, BusyOUT, DoneOUT, ErrOUT
    );
endinterface

// File: rtl/exposure_sequencer.sv
// Frame controller: pixel reset, timed exposure, then row-by-row ADC conversion with timeout.
// All outputs come straight from flops, so no input reaches an output combinationally.
module exposure_sequencer #(
    parameter int EXP_W     = 8,
    parameter int ROWS      = 4,
    parameter int ROW_W     = 2,
    parameter int RESET_CYC = 2,
    parameter int CONV_TMO  = 15
) (
    input logic        CLK,
    input logic        nResetIN,
    exposure_if.slave  bus
);
    localparam int TMO_W = $clog2(CONV_TMO + 1);
    localparam int RST_W = $clog2(RESET_CYC + 1);
    localparam int AUX_W = (TMO_W > RST_W) ? TMO_W : RST_W;
    localparam int CNT_W = (EXP_W > AUX_W) ? EXP_W : AUX_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_NEXT    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic               err_q, err_d;
    logic               fsm_run_q, fsm_run_d;
    logic               fsm_reset_q, fsm_reset_d;
    logic               conv_q, conv_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge nResetIN) begin
        if (!nResetIN) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            row_q       <= {ROW_W{1'b0}};
            exp_q       <= {EXP_W{1'b0}};
            err_q       <= 1'b0;
            fsm_run_q   <= 1'b0;
            fsm_reset_q <= 1'b0;
            conv_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            exp_q       <= exp_d;
            err_q       <= err_d;
            fsm_run_q   <= fsm_run_d;
            fsm_reset_q <= fsm_reset_d;
            conv_q      <= conv_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic; abort outranks every other transition, and ErrOUT survives it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        exp_d   = exp_q;
        err_d   = err_q;
        if ((state_q != S_IDLE) && bus.AbortIN) begin
            state_d = S_IDLE;
            cnt_d   = {CNT_W{1'b0}};
            row_d   = {ROW_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.StartIN) begin
                        state_d = S_RESET;
                        cnt_d   = {CNT_W{1'b0}};
                        exp_d   = (bus.ExpTimeIN == {EXP_W{1'b0}}) ? EXP_W'(1) : bus.ExpTimeIN;
                        err_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RESET: begin
                    if (cnt_q == CNT_W'(RESET_CYC - 1)) begin
                        state_d = S_EXPOSE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_EXPOSE: begin
                    if ((cnt_q + CNT_W'(1)) == CNT_W'(exp_q)) begin
                        state_d = S_CONVERT;
                        cnt_d   = {CNT_W{1'b0}};
                        row_d   = {ROW_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_CONVERT: begin
                    // A conversion finishing on the timeout cycle still counts as good.
                    if (bus.ConvDoneIN) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = (row_q == ROW_W'(ROWS - 1)) ? S_DONE : S_NEXT;
                    end else if (cnt_q == CNT_W'(CONV_TMO - 1)) begin
                        cnt_d   = {CNT_W{1'b0}};
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_NEXT: begin
                    state_d = S_CONVERT;
                    cnt_d   = {CNT_W{1'b0}};
                    row_d   = row_q + ROW_W'(1);
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    row_d   = {ROW_W{1'b0}};
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    row_d   = {ROW_W{1'b0}};
                end
            endcase
        end
    end

    // Output decode from the upcoming state, registered so each flop matches its state.
    always_comb begin
        fsm_run_d   = (state_d == S_EXPOSE);
        fsm_reset_d = (state_d == S_RESET);
        conv_d      = (state_d == S_CONVERT);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    assign bus.FsmRunOUT   = fsm_run_q;
    assign bus.FsmResetOUT = fsm_reset_q;
    assign bus.RowAddrOUT  = row_q;
    assign bus.ConvOUT     = conv_q;
    assign bus.BusyOUT     = busy_q;
    assign bus.DoneOUT     = done_q;
    assign bus.ErrOUT      = err_q;
endmodule

// File: tb/tb_exposure_sequencer.sv
// Bench for exposure_sequencer: each frame is expanded from its timing rules into a
// per-cycle stimulus/expectation trace, driven into the DUT, and compared cycle by cycle.
module tb_exposure_sequencer;
    localparam int ROWS      = 4;
    localparam int RESET_CYC = 2;
    localparam int CONV_TMO  = 15;

    typedef struct packed {
        logic       start;
        logic       abort;
        logic       cdone;
        logic [7:0] xt;
    } stim_t;

    typedef struct packed {
        logic       run;
        logic       rst;
        logic       conv;
        logic       busy;
        logic       done;
        logic       err;
        logic [1:0] row;
    } out_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   err_m;

    stim_t stim_q[$];
    out_t  exp_q[$];
    bit    care_q[$];
    out_t  obs_q[$];

    exposure_if #(.EXP_W(8), .ROW_W(2)) bus ();

    exposure_sequencer #(
        .EXP_W(8), .ROWS(ROWS), .ROW_W(2), .RESET_CYC(RESET_CYC), .CONV_TMO(CONV_TMO)
    ) dut (
        .CLK(clk),
        .nResetIN(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(bit run, bit rs, bit conv, bit busy, bit done, bit err, int row);
        logic [1:0] r;
        r = row[1:0];
        return '{run: run, rst: rs, conv: conv, busy: busy, done: done, err: err, row: r};
    endfunction

    function automatic stim_t mk_stim(bit s, bit a, bit c, logic [7:0] x);
        return '{start: s, abort: a, cdone: c, xt: x};
    endfunction

    function automatic bit hs(bit hold);
        return hold ? 1'b1 : ($urandom_range(0, 3) == 0);
    endfunction

    function automatic bit rb();
        return $urandom_range(0, 1) == 1;
    endfunction

    function automatic logic [7:0] rx();
        return 8'($urandom_range(0, 255));
    endfunction

    function automatic out_t sample();
        out_t o;
        o = {bus.FsmRunOUT, bus.FsmResetOUT, bus.ConvOUT, bus.BusyOUT,
             bus.DoneOUT, bus.ErrOUT, bus.RowAddrOUT};
        return o;
    endfunction

    task automatic push(input stim_t s, input out_t o, input bit care);
        stim_q.push_back(s);
        exp_q.push_back(o);
        care_q.push_back(care);
    endtask

    task automatic trunc(input int n);
        while (stim_q.size() > n) begin
            void'(stim_q.pop_back());
            void'(exp_q.pop_back());
            void'(care_q.pop_back());
        end
    endtask

    task automatic clear_traces();
        stim_q.delete();
        exp_q.delete();
        care_q.delete();
        obs_q.delete();
    endtask

    // Idle cycles: abort and ConvDoneIN noise must be ignored.
    task automatic gen_idle(input int n);
        repeat (n) push(mk_stim(1'b0, rb(), rb(), rx()), mk(0, 0, 0, 0, 0, err_m, 0), 1'b1);
    endtask

    // One frame from its start cycle; dN = cycle (1-based) of ConvOUT on which ConvDoneIN
    // is raised for row N, values above CONV_TMO mean no answer. abort_at indexes busy cycles.
    task automatic gen_frame(input int exp_time, input int d0, input int d1, input int d2,
                             input int d3, input int abort_at, input bit hold);
        int dl[4];
        int e;
        int base;
        int nconv;
        bit stop;
        dl = '{d0, d1, d2, d3};
        push(mk_stim(1'b1, rb(), rb(), exp_time[7:0]), mk(0, 0, 0, 0, 0, err_m, 0), 1'b1);
        err_m = 1'b0;
        base  = stim_q.size();
        e     = (exp_time == 0) ? 1 : exp_time;
        stop  = 1'b0;
        repeat (RESET_CYC) push(mk_stim(hs(hold), 1'b0, rb(), rx()), mk(0, 1, 0, 1, 0, 0, 0), 1'b0);
        repeat (e) push(mk_stim(hs(hold), 1'b0, rb(), rx()), mk(1, 0, 0, 1, 0, 0, 0), 1'b0);
        for (int r = 0; r < ROWS && !stop; r++) begin
            nconv = (dl[r] > CONV_TMO) ? CONV_TMO : dl[r];
            for (int k = 1; k <= nconv; k++)
                push(mk_stim(hs(hold), 1'b0, k == dl[r], rx()), mk(0, 0, 1, 1, 0, 0, r), 1'b1);
            if (dl[r] > CONV_TMO) begin
                err_m = 1'b1;
                stop  = 1'b1;
            end else if (r < ROWS - 1) begin
                push(mk_stim(hs(hold), 1'b0, rb(), rx()), mk(0, 0, 0, 1, 0, 0, r), 1'b0);
            end
        end
        push(mk_stim(hs(hold), 1'b0, rb(), rx()), mk(0, 0, 0, 1, 1, err_m, 0), 1'b0);
        if (abort_at >= 0 && abort_at < stim_q.size() - base) begin
            trunc(base + abort_at + 1);
            stim_q[stim_q.size() - 1].abort = 1'b1;
            err_m = exp_q[exp_q.size() - 1].err;
        end
    endtask

    // Inputs change just after the rising edge; outputs are captured on the falling edge.
    task automatic play();
        obs_q.delete();
        foreach (stim_q[i]) begin
            @(posedge clk);
            #1;
            bus.StartIN    = stim_q[i].start;
            bus.AbortIN    = stim_q[i].abort;
            bus.ConvDoneIN = stim_q[i].cdone;
            bus.ExpTimeIN  = stim_q[i].xt;
            @(negedge clk);
            obs_q.push_back(sample());
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sample() !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: got %b expected %b", sample(), 8'h00);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            bus.StartIN    = 1'b1;
            bus.ConvDoneIN = 1'b1;
            bus.ExpTimeIN  = rx();
            @(negedge clk);
            checks++;
            if (sample() !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold: got %b expected %b", sample(), 8'h00);
            end
        end
        bus.StartIN    = 1'b0;
        bus.ConvDoneIN = 1'b0;
        rst_n          = 1'b1;
    endtask

    task automatic test_nominal();
        int n_run;
        int n_rst;
        int n_done;
        clear_traces();
        gen_idle(2);
        gen_frame(5, 3, 3, 3, 3, -1, 1'b0);
        gen_idle(2);
        play();
        n_run = 0; n_rst = 0; n_done = 0;
        foreach (exp_q[i]) begin
            checks++;
            if ((obs_q[i] & (care_q[i] ? 8'hFF : 8'hFC)) !== (exp_q[i] & (care_q[i] ? 8'hFF : 8'hFC))) begin
                errors++;
                $display("FAIL nominal cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
            n_run  += int'(obs_q[i].run);
            n_rst  += int'(obs_q[i].rst);
            n_done += int'(obs_q[i].done);
        end
        checks += 3;
        if (n_run != 5) begin errors++; $display("FAIL nominal_run_len: got %0d expected 5", n_run); end
        if (n_rst != RESET_CYC) begin errors++; $display("FAIL nominal_rst_len: got %0d expected %0d", n_rst, RESET_CYC); end
        if (n_done != 1) begin errors++; $display("FAIL nominal_done_cnt: got %0d expected 1", n_done); end
    endtask

    task automatic test_zero_exp();
        int n_run;
        clear_traces();
        gen_frame(0, 2, 1, 4, 2, -1, 1'b0);
        gen_idle(2);
        play();
        n_run = 0;
        foreach (exp_q[i]) begin
            checks++;
            if ((obs_q[i] & (care_q[i] ? 8'hFF : 8'hFC)) !== (exp_q[i] & (care_q[i] ? 8'hFF : 8'hFC))) begin
                errors++;
                $display("FAIL zero_exp cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
            n_run += int'(obs_q[i].run);
        end
        checks++;
        if (n_run != 1) begin errors++; $display("FAIL zero_exp_run_len: got %0d expected 1", n_run); end
    endtask

    task automatic test_timeout();
        clear_traces();
        gen_frame(3, 16, 2, 2, 2, -1, 1'b0);
        gen_idle(3);
        gen_frame(2, 1, 15, 16, 2, -1, 1'b0);
        gen_idle(1);
        gen_frame(1, 2, 2, 2, 2, -1, 1'b0);
        gen_idle(2);
        play();
        foreach (exp_q[i]) begin
            checks++;
            if ((obs_q[i] & (care_q[i] ? 8'hFF : 8'hFC)) !== (exp_q[i] & (care_q[i] ? 8'hFF : 8'hFC))) begin
                errors++;
                $display("FAIL timeout cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_abort();
        clear_traces();
        gen_frame(8, 2, 2, 2, 2, RESET_CYC + 3, 1'b0);
        gen_idle(2);
        gen_frame(2, 2, 2, 4, 2, RESET_CYC + 2 + 2 + 1 + 2 + 1 + 1, 1'b0);
        gen_idle(2);
        gen_frame(2, 16, 2, 2, 2, RESET_CYC + 2 + 14, 1'b0);
        gen_idle(2);
        play();
        foreach (exp_q[i]) begin
            checks++;
            if ((obs_q[i] & (care_q[i] ? 8'hFF : 8'hFC)) !== (exp_q[i] & (care_q[i] ? 8'hFF : 8'hFC))) begin
                errors++;
                $display("FAIL abort cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_done;
        clear_traces();
        gen_frame(4, 3, 1, 2, 2, -1, 1'b1);
        gen_frame(2, 2, 2, 2, 2, -1, 1'b1);
        gen_frame(0, 1, 1, 1, 1, -1, 1'b0);
        gen_idle(2);
        play();
        n_done = 0;
        foreach (exp_q[i]) begin
            checks++;
            if ((obs_q[i] & (care_q[i] ? 8'hFF : 8'hFC)) !== (exp_q[i] & (care_q[i] ? 8'hFF : 8'hFC))) begin
                errors++;
                $display("FAIL b2b cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
            n_done += int'(obs_q[i].done);
        end
        checks++;
        if (n_done != 3) begin errors++; $display("FAIL b2b_done_cnt: got %0d expected 3", n_done); end
    endtask

    task automatic test_async_reset();
        int s;
        clear_traces();
        gen_frame(3, 16, 2, 2, 2, -1, 1'b0);
        gen_idle(2);
        play();
        foreach (exp_q[i]) begin
            checks++;
            if ((obs_q[i] & (care_q[i] ? 8'hFF : 8'hFC)) !== (exp_q[i] & (care_q[i] ? 8'hFF : 8'hFC))) begin
                errors++;
                $display("FAIL areset_pre cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sample() !== 8'h00) begin errors++; $display("FAIL areset_idle_err: got %b expected %b", sample(), 8'h00); end
        @(negedge clk);
        rst_n = 1'b1;
        err_m = 1'b0;
        clear_traces();
        gen_idle(1);
        s = stim_q.size();
        gen_frame(3, 2, 5, 2, 2, -1, 1'b0);
        trunc(s + 1 + RESET_CYC + 3 + 2 + 1 + 2);
        play();
        foreach (exp_q[i]) begin
            checks++;
            if ((obs_q[i] & (care_q[i] ? 8'hFF : 8'hFC)) !== (exp_q[i] & (care_q[i] ? 8'hFF : 8'hFC))) begin
                errors++;
                $display("FAIL areset_mid cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sample() !== 8'h00) begin errors++; $display("FAIL areset_conv: got %b expected %b", sample(), 8'h00); end
        bus.StartIN = 1'b0;
        bus.AbortIN = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        err_m = 1'b0;
        clear_traces();
        gen_idle(1);
        gen_frame(5, 3, 3, 3, 3, -1, 1'b0);
        gen_idle(2);
        play();
        foreach (exp_q[i]) begin
            checks++;
            if ((obs_q[i] & (care_q[i] ? 8'hFF : 8'hFC)) !== (exp_q[i] & (care_q[i] ? 8'hFF : 8'hFC))) begin
                errors++;
                $display("FAIL areset_post cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        clear_traces();
        for (int f = 0; f < 25; f++) begin
            gen_frame($urandom_range(0, 12), $urandom_range(1, 16), $urandom_range(1, 16),
                      $urandom_range(1, 16), $urandom_range(1, 16),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1,
                      $urandom_range(0, 1) == 1);
            gen_idle($urandom_range(0, 3));
        end
        gen_idle(2);
        play();
        foreach (exp_q[i]) begin
            checks++;
            if ((obs_q[i] & (care_q[i] ? 8'hFF : 8'hFC)) !== (exp_q[i] & (care_q[i] ? 8'hFF : 8'hFC))) begin
                errors++;
                $display("FAIL random cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        rst_n          = 1'b1;
        bus.StartIN    = 1'b0;
        bus.AbortIN    = 1'b0;
        bus.ConvDoneIN = 1'b0;
        bus.ExpTimeIN  = 8'd0;
        checks         = 0;
        errors         = 0;
        err_m          = 1'b0;
        test_reset();
        test_nominal();
        test_zero_exp();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
